// File: rtl/wb_load_align_if.sv
// MEM/WB boundary bundle: MEM-stage instruction, data-memory response,
// flush, stall back-pressure and the register-file write port.
interface wb_load_align_if #(
  parameter int DW  = 32,
  parameter int RAW = 5
);
  logic           m_valid;
  logic [3:0]     m_wreg;
  logic [RAW-1:0] m_wraddr;
  logic [DW-1:0]  m_alures;
  logic           m_isload;
  logic [2:0]     m_ldtype;
  logic [1:0]     m_addr_lo;
  logic           d_rvalid;
  logic [DW-1:0]  d_rdata;
  logic           flush;
  logic           stall_req;
  logic [3:0]     wb_we;
  logic [RAW-1:0] wb_waddr;
  logic [DW-1:0]  wb_wdata;

  modport master (
    output m_valid, m_wreg, m_wraddr, m_alures, m_isload, m_ldtype, m_addr_lo,
    output d_rvalid, d_rdata, flush,
    input  stall_req, wb_we, wb_waddr, wb_wdata
  );

  modport slave (
    input  m_valid, m_wreg, m_wraddr, m_alures, m_isload, m_ldtype, m_addr_lo,
    input  d_rvalid, d_rdata, flush,
    output stall_req, wb_we, wb_waddr, wb_wdata
  );
endinterface

// File: rtl/wb_load_align.sv
// MEM/WB stage: registers ALU results, waits for load responses and aligns
// them (LB/LBU/LH/LHU/LW/LWL/LWR) into register-file byte writes.
module wb_load_align #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic            clk,
  input  logic            rst,
  wb_load_align_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t         r_state;
  logic [3:0]     r_we;
  logic [RAW-1:0] r_waddr;
  logic [DW-1:0]  r_wdata;
  logic [RAW-1:0] r_ldaddr;
  logic [2:0]     r_ldtype;
  logic [1:0]     r_k;

  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [DW-1:0]  w_ld_data;
  logic [3:0]     w_ld_we;

  always_comb begin
    w_byte    = '0;
    w_half    = r_k[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];
    w_ld_data = bus.d_rdata;
    w_ld_we   = '1;
    case (r_k)
      2'd0:    w_byte = bus.d_rdata[7:0];
      2'd1:    w_byte = bus.d_rdata[15:8];
      2'd2:    w_byte = bus.d_rdata[23:16];
      default: w_byte = bus.d_rdata[31:24];
    endcase
    case (r_ldtype)
      3'd1: w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'd2: w_ld_data = {24'h0, w_byte};
      3'd3: w_ld_data = {{16{w_half[15]}}, w_half};
      3'd4: w_ld_data = {16'h0, w_half};
      3'd5: begin
        // LWL: memory bytes 0..k land in the top k+1 register lanes
        case (r_k)
          2'd0:    begin w_ld_data = {bus.d_rdata[7:0], 24'h0};  w_ld_we = 4'b1000; end
          2'd1:    begin w_ld_data = {bus.d_rdata[15:0], 16'h0}; w_ld_we = 4'b1100; end
          2'd2:    begin w_ld_data = {bus.d_rdata[23:0], 8'h0};  w_ld_we = 4'b1110; end
          default: begin w_ld_data = bus.d_rdata;                w_ld_we = 4'b1111; end
        endcase
      end
      3'd6: begin
        case (r_k)
          2'd0:    begin w_ld_data = bus.d_rdata;                 w_ld_we = 4'b1111; end
          2'd1:    begin w_ld_data = {8'h0, bus.d_rdata[31:8]};   w_ld_we = 4'b0111; end
          2'd2:    begin w_ld_data = {16'h0, bus.d_rdata[31:16]}; w_ld_we = 4'b0011; end
          default: begin w_ld_data = {24'h0, bus.d_rdata[31:24]}; w_ld_we = 4'b0001; end
        endcase
      end
      default: w_ld_data = bus.d_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_we     <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_ldaddr <= '0;
      r_ldtype <= '0;
      r_k      <= '0;
    end else begin
      r_we <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.m_valid && !bus.flush) begin
            if (bus.m_isload) begin
              r_ldaddr <= bus.m_wraddr;
              r_ldtype <= bus.m_ldtype;
              r_k      <= bus.m_addr_lo;
              r_state  <= S_WAIT;
            end else begin
              r_we    <= (bus.m_wraddr == '0) ? 4'b0000 : bus.m_wreg;
              r_waddr <= bus.m_wraddr;
              r_wdata <= bus.m_alures;
            end
          end
        end
        S_WAIT: begin
          if (bus.d_rvalid && !bus.flush) begin
            r_we    <= (r_ldaddr == '0) ? 4'b0000 : w_ld_we;
            r_waddr <= r_ldaddr;
            r_wdata <= w_ld_data;
            r_state <= S_IDLE;
          end else if (bus.flush) begin
            // flush coinciding with the response consumes it; otherwise drain it later
            r_state <= bus.d_rvalid ? S_IDLE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.d_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_req = (r_state != S_IDLE);
  assign bus.wb_we     = r_we;
  assign bus.wb_waddr  = r_waddr;
  assign bus.wb_wdata  = r_wdata;

endmodule

// File: tb/tb_wb_load_align.sv
// Bench for wb_load_align: directed scenarios then random traffic, checked
// against a transaction-level reference of the write-back behaviour.
module tb_wb_load_align;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_load_align_if #(.DW(32), .RAW(5)) bus();
  wb_load_align #(.DW(32), .RAW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // reference: outstanding load (0 none, 1 awaiting, 2 flushed) and expected write
  int          pend = 0;
  logic [4:0]  p_addr;
  logic [2:0]  p_type;
  int          p_k;
  logic [3:0]  exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  bit          exp_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic void ref_align(input logic [2:0] t, input int k, input logic [31:0] d,
                                    output logic [3:0] we, output logic [31:0] wd);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    h  = {b[2*(k/2)+1], b[2*(k/2)]};
    we = 4'b1111;
    wd = d;
    case (t)
      3'd1: wd = int'($signed(b[k]));
      3'd2: wd = 32'(b[k]);
      3'd3: wd = int'($signed(h));
      3'd4: wd = 32'(h);
      3'd5: begin
        we = '0; wd = '0;
        for (int i = 3 - k; i < 4; i++) begin we[i] = 1'b1; wd[8*i +: 8] = b[i-(3-k)]; end
      end
      3'd6: begin
        we = '0; wd = '0;
        for (int i = 0; i <= 3 - k; i++) begin we[i] = 1'b1; wd[8*i +: 8] = b[i+k]; end
      end
      default: ;
    endcase
  endfunction

  task automatic model_edge();
    exp_we = '0;
    exp_wr = 1'b0;
    if (pend == 0) begin
      if (bus.m_valid && !bus.flush) begin
        if (bus.m_isload) begin
          pend = 1; p_addr = bus.m_wraddr; p_type = bus.m_ldtype; p_k = int'(bus.m_addr_lo);
        end else begin
          exp_wr = 1'b1; exp_waddr = bus.m_wraddr; exp_wdata = bus.m_alures;
          exp_we = (bus.m_wraddr == 0) ? 4'b0000 : bus.m_wreg;
        end
      end
    end else if (pend == 1) begin
      if (bus.d_rvalid) begin
        if (!bus.flush) begin
          ref_align(p_type, p_k, bus.d_rdata, exp_we, exp_wdata);
          exp_wr = 1'b1; exp_waddr = p_addr;
          if (p_addr == 0) exp_we = '0;
        end
        pend = 0;
      end else if (bus.flush) pend = 2;
    end else begin
      if (bus.d_rvalid) pend = 0;
    end
  endtask

  task automatic compare_all();
    logic [31:0] mask;
    check("stall", 32'(bus.stall_req), 32'(pend != 0));
    check("we", 32'(bus.wb_we), 32'(exp_we));
    if (exp_wr) begin
      check("waddr", 32'(bus.wb_waddr), 32'(exp_waddr));
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{exp_we[i]}};
      if (exp_we != 0) check("wdata", bus.wb_wdata & mask, exp_wdata & mask);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.m_valid = 0; bus.m_wreg = '0; bus.m_wraddr = '0; bus.m_alures = '0;
    bus.m_isload = 0; bus.m_ldtype = '0; bus.m_addr_lo = '0;
    bus.d_rvalid = 0; bus.d_rdata = '0; bus.flush = 0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [3:0] w, input logic [31:0] r);
    idle(); bus.m_valid = 1; bus.m_wraddr = a; bus.m_wreg = w; bus.m_alures = r;
  endtask

  task automatic load(input logic [4:0] a, input logic [2:0] t, input logic [1:0] k);
    idle(); bus.m_valid = 1; bus.m_isload = 1; bus.m_wraddr = a; bus.m_ldtype = t;
    bus.m_addr_lo = k; bus.m_wreg = 4'b1111;
  endtask

  task automatic rsp(input logic [31:0] d);
    idle(); bus.d_rvalid = 1; bus.d_rdata = d;
  endtask

  task automatic reset_model();
    pend = 0; exp_we = '0; exp_wr = 1'b0;
  endtask

  initial begin
    idle();
    rst = 0;
    reset_model();
    #1;
    check("rst_we", 32'(bus.wb_we), 32'h0);
    check("rst_waddr", 32'(bus.wb_waddr), 32'h0);
    check("rst_wdata", bus.wb_wdata, 32'h0);
    check("rst_stall", 32'(bus.stall_req), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;

    alu(5'd5, 4'hF, 32'hDEADBEEF); step();
    check("alu_wdata", bus.wb_wdata, 32'hDEADBEEF);
    idle(); step();

    load(5'd7, 3'd1, 2'd3); step();
    idle(); step(); step();
    rsp(32'h80112233); step();
    check("lb_wdata", bus.wb_wdata, 32'hFFFFFF80);
    idle(); step();

    load(5'd8, 3'd5, 2'd1); step();
    rsp(32'hAABBCCDD); step();
    check("lwl_hi", 32'(bus.wb_wdata[31:16]), 32'h0000CCDD);
    load(5'd8, 3'd6, 2'd2); step();
    idle(); step();
    rsp(32'hAABBCCDD); step();
    check("lwr_lo", 32'(bus.wb_wdata[15:0]), 32'h0000AABB);

    load(5'd0, 3'd4, 2'd2); step();
    rsp(32'h12345678); step();
    check("r0_we", 32'(bus.wb_we), 32'h0);
    idle(); step();

    load(5'd9, 3'd0, 2'd0); step();
    idle(); bus.flush = 1; step();
    idle(); step();
    rsp(32'h55555555); step();
    idle(); step();
    load(5'd10, 3'd0, 2'd0); step();
    rsp(32'hCAFEF00D); step();
    check("after_drain", bus.wb_wdata, 32'hCAFEF00D);

    load(5'd11, 3'd2, 2'd1); step();
    idle(); step();
    rsp(32'h0000AB00); bus.m_valid = 1; bus.m_wraddr = 5'd12; step();
    alu(5'd12, 4'hF, 32'h00001234); step();
    idle(); step();

    for (int i = 0; i < 1500; i++) begin
      bus.m_valid   = ($urandom % 3) != 0;
      bus.m_isload  = ($urandom % 2) != 0;
      bus.m_wreg    = 4'($urandom);
      bus.m_wraddr  = 5'($urandom);
      bus.m_alures  = $urandom;
      bus.m_ldtype  = 3'($urandom);
      bus.m_addr_lo = 2'($urandom);
      bus.d_rdata   = $urandom;
      bus.flush     = ($urandom % 12) == 0;
      if (pend != 0) bus.d_rvalid = ($urandom % 3) == 0;
      else if (!(bus.m_valid && bus.m_isload && !bus.flush)) bus.d_rvalid = ($urandom % 8) == 0;
      else bus.d_rvalid = 0;
      step();
      if (i == 700) begin
        #2 rst = 0;
        reset_model();
        #1;
        check("mid_rst_we", 32'(bus.wb_we), 32'h0);
        check("mid_rst_stall", 32'(bus.stall_req), 32'h0);
        check("mid_rst_wdata", bus.wb_wdata, 32'h0);
        #1 rst = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
